// File: rtl/mem_pkg.sv
// Shared definitions for the data memory port: command codes, pointer
// select codes and FSM state encodings.
// Optional feature macro used by this slice: DATA_MEM_STATS_EN.
package mem_pkg;

    // Control-unit memory command
    typedef enum logic [1:0] {
        MEM_IDLE  = 2'd0,
        MEM_READ  = 2'd1,
        MEM_WRITE = 2'd2,
        MEM_RSVD  = 2'd3
    } mem_cmd_e;

    // Address source select
    typedef enum logic [1:0] {
        P_GSP = 2'd0,
        P_RP  = 2'd1,
        P_CP  = 2'd2,
        P_STP = 2'd3
    } ptr_sel_e;

    // Access FSM: records what completed on the last edge
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2
    } mem_state_e;

endpackage

// File: rtl/spram_sync.sv
// Single-port synchronous RAM with a registered read port.
// The read register only loads on re, so it holds across writes and idles.
module spram_sync #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    // Storage array: contents survive reset
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    // Registered read data, cleared by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/data_mem_port.sv
// Memory-side responder to the control unit's memory command interface.
// Selects the access address from the pointer registers, arbitrates the
// host preload port against control-unit accesses (control unit wins) and
// presents registered read data on mem_out.
// Optional feature: DATA_MEM_STATS_EN adds saturating read/write counters.
module data_mem_port
    import mem_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        mem_ctrl,
    input  logic [1:0]        p_ctrl,
    input  logic [ADDR_W-1:0] gsp_addr,
    input  logic [ADDR_W-1:0] rp_addr,
    input  logic [ADDR_W-1:0] cp_addr,
    input  logic [ADDR_W-1:0] stp_addr,
    input  logic [DATA_W-1:0] bus_in,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_data,
`ifdef DATA_MEM_STATS_EN
    input  logic              stats_clr,
    output logic [CNT_W-1:0]  rd_count,
    output logic [CNT_W-1:0]  wr_count,
`endif
    output logic [DATA_W-1:0] mem_out,
    output logic              rd_valid,
    output logic              wr_ack,
    output logic              host_drop,
    output logic              cmd_err
);

    mem_cmd_e          cmd;
    ptr_sel_e          psel;
    mem_state_e        state;
    logic [ADDR_W-1:0] cu_addr;
    logic              cu_rd;
    logic              cu_wr;
    logic              host_ok;
    logic              ram_we;
    logic              ram_re;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;

    assign cmd  = mem_cmd_e'(mem_ctrl);
    assign psel = ptr_sel_e'(p_ctrl);

    // Pointer select for control-unit accesses
    always_comb begin
        cu_addr = gsp_addr;
        unique case (psel)
            P_GSP: cu_addr = gsp_addr;
            P_RP:  cu_addr = rp_addr;
            P_CP:  cu_addr = cp_addr;
            P_STP: cu_addr = stp_addr;
        endcase
    end

    // Arbitration: control unit owns the RAM port whenever it reads or
    // writes; the host only gets through on idle/reserved cycles. Every
    // access is gated off while rst is asserted.
    always_comb begin
        cu_rd     = (cmd == MEM_READ);
        cu_wr     = (cmd == MEM_WRITE);
        host_ok   = host_we && !cu_rd && !cu_wr;
        ram_re    = !rst && cu_rd;
        ram_we    = !rst && (cu_wr || host_ok);
        ram_addr  = (cu_rd || cu_wr) ? cu_addr : host_addr;
        ram_wdata = cu_wr ? bus_in : host_data;
    end

    spram_sync #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (ram_we),
        .re    (ram_re),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (mem_out)
    );

    // Access FSM plus host-drop pulse and sticky reserved-command flag
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            host_drop <= 1'b0;
            cmd_err   <= 1'b0;
        end else begin
            host_drop <= host_we && (cu_rd || cu_wr);
            if (cmd == MEM_RSVD) begin
                cmd_err <= 1'b1;
            end
            unique case (cmd)
                MEM_READ:  state <= ST_RD;
                MEM_WRITE: state <= ST_WR;
                default:   state <= ST_IDLE;
            endcase
        end
    end

    assign rd_valid = (state == ST_RD);
    assign wr_ack   = (state == ST_WR);

`ifdef DATA_MEM_STATS_EN
    // Saturating counters of committed control-unit reads and writes
    always_ff @(posedge clk) begin
        if (rst || stats_clr) begin
            rd_count <= '0;
            wr_count <= '0;
        end else begin
            if (cu_rd && rd_count != '1) begin
                rd_count <= rd_count + 1'b1;
            end
            if (cu_wr && wr_count != '1) begin
                wr_count <= wr_count + 1'b1;
            end
        end
    end
`endif

endmodule
